// File: rtl/battleship_vga_renderer.sv
// battleship_vga_renderer: 640x480@60 VGA renderer for the 10x10 board with a per-frame shadow snapshot.
// Define BATTLESHIP_GRID_LINES_EN to draw 0x444 grid lines on cell edges.
module battleship_vga_renderer #(
  parameter int GRID_X0  = 120,
  parameter int GRID_Y0  = 40,
  parameter int CELL_PX  = 40,
  parameter int CURSOR_W = 2,
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [399:0] cell_state_flat,
  input  logic [6:0]   selected_cell,
  output logic         hsync,
  output logic         vsync,
  output logic [11:0]  rgb,
  output logic         video_active,
  output logic         frame_start
);
  localparam logic [9:0] H_MAX = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_MAX = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HV = 10'(H_VIS), HS0 = 10'(H_VIS + H_FP), HS1 = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VV = 10'(V_VIS), VS0 = 10'(V_VIS + V_FP), VS1 = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] GX0 = 10'(GRID_X0), GX1 = 10'(GRID_X0 + 10 * CELL_PX);
  localparam logic [9:0] GY0 = 10'(GRID_Y0), GY1 = 10'(GRID_Y0 + 10 * CELL_PX);
  localparam logic [5:0] C_LAST = 6'(CELL_PX - 1), C_W = 6'(CURSOR_W), C_WH = 6'(CELL_PX - CURSOR_W);
  logic [9:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [5:0]   hpx_q, hpx_d, vpx_q, vpx_d;
  logic [3:0]   col_q, col_d, row_q, row_d;
  logic [399:0] cells_q;
  logic [6:0]   sel_q;
  logic         hwrap, snap, in_grid, edge_px, line_px;
  logic [6:0]   idx;
  logic         s1_vis_q, s1_hs_q, s1_vs_q, s1_fs_q, s1_in_q, s1_cur_q, s1_line_q;
  logic [6:0]   s1_idx_q;
  logic [3:0]   st;
  logic [11:0]  rgb_d;
  // Sub-counters hold pixel-within-cell and cell column/row for the current hcnt/vcnt.
  always_comb begin
    hwrap = hcnt_q == H_MAX;
    hcnt_d = hwrap ? '0 : hcnt_q + 10'd1;
    vcnt_d = !hwrap ? vcnt_q : vcnt_q == V_MAX ? '0 : vcnt_q + 10'd1;
    hpx_d = (hcnt_d == GX0 || hpx_q == C_LAST) ? '0 : hpx_q + 6'd1;
    col_d = hcnt_d == GX0 ? '0 : hpx_q == C_LAST ? col_q + 4'd1 : col_q;
    vpx_d = !hwrap ? vpx_q : (vcnt_d == GY0 || vpx_q == C_LAST) ? '0 : vpx_q + 6'd1;
    row_d = !hwrap ? row_q : vcnt_d == GY0 ? '0 : vpx_q == C_LAST ? row_q + 4'd1 : row_q;
    snap = hcnt_q == '0 && vcnt_q == VV;
    idx = {row_q, 3'b0} + {2'b0, row_q, 1'b0} + {3'b0, col_q};
    in_grid = hcnt_q >= GX0 && hcnt_q < GX1 && vcnt_q >= GY0 && vcnt_q < GY1;
    edge_px = hpx_q < C_W || hpx_q >= C_WH || vpx_q < C_W || vpx_q >= C_WH;
`ifdef BATTLESHIP_GRID_LINES_EN
    line_px = hpx_q == '0 || vpx_q == '0 || hcnt_q == GX1 - 10'd1 || vcnt_q == GY1 - 10'd1;
`else
    line_px = 1'b0;
`endif
    st = cells_q[{s1_idx_q, 2'b0} +: 4];
    rgb_d = (!s1_vis_q || !s1_in_q) ? 12'h000 : s1_cur_q ? 12'hFF0 : s1_line_q ? 12'h444 :
            st == 4'd1 ? 12'hFFF : st == 4'd2 ? 12'hF80 : st == 4'd3 ? 12'hF00 : 12'h00A;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      hpx_q <= '0;
      vpx_q <= '0;
      col_q <= '0;
      row_q <= '0;
      cells_q <= '0;
      sel_q <= 7'd127;
      s1_vis_q <= 1'b0;
      s1_hs_q <= 1'b1;
      s1_vs_q <= 1'b1;
      s1_fs_q <= 1'b0;
      s1_in_q <= 1'b0;
      s1_cur_q <= 1'b0;
      s1_line_q <= 1'b0;
      s1_idx_q <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb <= '0;
      video_active <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      hpx_q <= hpx_d;
      vpx_q <= vpx_d;
      col_q <= col_d;
      row_q <= row_d;
      if (snap) begin
        cells_q <= cell_state_flat;
        sel_q <= selected_cell;
      end
      s1_vis_q <= hcnt_q < HV && vcnt_q < VV;
      s1_hs_q <= !(hcnt_q >= HS0 && hcnt_q < HS1);
      s1_vs_q <= !(vcnt_q >= VS0 && vcnt_q < VS1);
      s1_fs_q <= hcnt_q == '0 && vcnt_q == '0;
      s1_in_q <= in_grid;
      s1_cur_q <= in_grid && edge_px && idx == sel_q;
      s1_line_q <= line_px;
      s1_idx_q <= idx;
      hsync <= s1_hs_q;
      vsync <= s1_vs_q;
      video_active <= s1_vis_q;
      frame_start <= s1_fs_q;
      rgb <= rgb_d;
    end
endmodule
